// File: rtl/sysid_checker.sv
// Avalon-MM master that reads both words of a sysid peripheral after reset or on
// request, compares them with the expected build values and reports the verdict.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h53061A9D,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic        timeout,
   output logic [31:0] id_q,
   output logic [31:0] ts_q
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_ID = 3'd1,
      RD_TS = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_r;
   logic [15:0] wait_cnt_r;
   logic        auto_r;
   logic        expire_s;

   function automatic logic word_differs(input logic [31:0] word, input logic [31:0] expected);
      return (word != expected);
   endfunction

   // The wait edge that brings the stall count to TIMEOUT_CYCLES ends the read.
   assign expire_s = avm_waitrequest && (wait_cnt_r == WAIT_LAST);

   // Check sequencer: issues both reads back to back, then registers the verdict.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         wait_cnt_r  <= 16'd0;
         auto_r      <= AUTO_START;
         avm_address <= 1'b0;
         avm_read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         id_mismatch <= 1'b0;
         ts_mismatch <= 1'b0;
         timeout     <= 1'b0;
         id_q        <= 32'd0;
         ts_q        <= 32'd0;
      end else begin
         auto_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start || (auto_r && state_r == IDLE)) begin
                  state_r     <= RD_ID;
                  wait_cnt_r  <= 16'd0;
                  avm_address <= 1'b0;
                  avm_read    <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  id_mismatch <= 1'b0;
                  ts_mismatch <= 1'b0;
                  timeout     <= 1'b0;
               end
            end
            RD_ID: begin
               if (!avm_waitrequest) begin
                  id_q        <= avm_readdata;
                  avm_address <= 1'b1;
                  wait_cnt_r  <= 16'd0;
                  state_r     <= RD_TS;
               end else if (expire_s) begin
                  avm_read <= 1'b0;
                  busy     <= 1'b0;
                  timeout  <= 1'b1;
                  pass     <= 1'b0;
                  done     <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 16'd1;
               end
            end
            RD_TS: begin
               if (!avm_waitrequest) begin
                  ts_q     <= avm_readdata;
                  avm_read <= 1'b0;
                  state_r  <= CHECK;
               end else if (expire_s) begin
                  avm_read <= 1'b0;
                  busy     <= 1'b0;
                  timeout  <= 1'b1;
                  pass     <= 1'b0;
                  done     <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 16'd1;
               end
            end
            CHECK: begin
               id_mismatch <= word_differs(id_q, EXPECTED_ID);
               ts_mismatch <= word_differs(ts_q, EXPECTED_TIMESTAMP);
               pass        <= !word_differs(id_q, EXPECTED_ID) && !word_differs(ts_q, EXPECTED_TIMESTAMP);
               done        <= 1'b1;
               busy        <= 1'b0;
               state_r     <= DONE;
            end
            default: begin
               state_r  <= IDLE;
               avm_read <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: a randomised sysid slave model feeds the DUT
// and a rule-based reference predicts the verdict, captured words and latency.
module tb_sysid_checker;

   localparam int          TO     = 8;
   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'h5306_1A9D;

   logic        clock, reset_n, start;
   logic        avm_address, avm_read, avm_waitrequest;
   logic [31:0] avm_readdata, id_q, ts_q;
   logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;

   typedef struct {
      logic        pass, idm, tsm, to;
      logic [31:0] id, ts;
      int          start_edge, lat;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          checks, errors, cyc;
   logic [31:0] mem [2];
   int          wcfg [2];
   logic [31:0] m_id, m_ts;
   logic        mon_done_prev;
   int          s_rem;
   logic        s_xfer, s_addr, s_prev_wait, s_prev_addr;

   sysid_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
      .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .done(done), .pass(pass),
      .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch), .timeout(timeout),
      .id_q(id_q), .ts_q(ts_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a read stalled TO or more edges times out; otherwise it takes stalls+1 edges.
   function automatic exp_t predict(input logic [31:0] id, input logic [31:0] ts,
                                    input int w0, input int w1, input int se);
      exp_t e;
      e.start_edge = se; e.to = 1'b0; e.idm = 1'b0; e.tsm = 1'b0; e.pass = 1'b0;
      if (w0 >= TO) begin
         e.to = 1'b1; e.lat = TO;
      end else begin
         m_id = id;
         if (w1 >= TO) begin
            e.to = 1'b1; e.lat = w0 + 1 + TO;
         end else begin
            m_ts  = ts;
            e.idm = (id != EXP_ID);
            e.tsm = (ts != EXP_TS);
            e.pass = !e.idm && !e.tsm;
            e.lat = w0 + w1 + 3;
         end
      end
      e.id = m_id; e.ts = m_ts;
      return e;
   endfunction

   task automatic configure(input logic [31:0] id, input logic [31:0] ts, input int w0, input int w1);
      mem[0] = id; mem[1] = ts; wcfg[0] = w0; wcfg[1] = w1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL wait_done: done still %b after %0d cycles, required 1", done, n);
      end
   endtask

   task automatic run_check(input logic [31:0] id, input logic [31:0] ts,
                            input int w0, input int w1, input bit extra_start);
      @(negedge clock);
      configure(id, ts, w0, w1);
      sbq.push_back(predict(id, ts, w0, w1, cyc + 1));
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("flags_clear", {26'd0, done, pass, id_mismatch, ts_mismatch, timeout, busy}, 32'h1);
      if (extra_start) begin
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      wait_done();
   endtask

   // Sysid slave: stalls each read for wcfg[addr] cycles, garbage data while stalled.
   initial begin
      avm_waitrequest = 1'b0; avm_readdata = 32'd0;
      s_rem = 0; s_xfer = 1'b0; s_addr = 1'b0; s_prev_wait = 1'b0; s_prev_addr = 1'b0;
      forever begin
         @(negedge clock);
         if (reset_n && s_prev_wait && !timeout) begin
            chk("read_held", {31'd0, avm_read}, 32'd1);
            chk("addr_held", {31'd0, avm_address}, {31'd0, s_prev_addr});
         end
         if (avm_read) begin
            if (!s_xfer || avm_address != s_addr) begin
               s_rem = wcfg[avm_address]; s_xfer = 1'b1; s_addr = avm_address;
            end else begin
               s_rem--;
            end
         end else begin
            s_xfer = 1'b0;
         end
         avm_waitrequest = avm_read && (s_rem > 0);
         avm_readdata    = avm_waitrequest ? $urandom : mem[avm_address];
         s_prev_wait     = avm_waitrequest;
         s_prev_addr     = avm_address;
      end
   end

   // Monitor: every rising done retires one scoreboard entry.
   initial begin
      mon_done_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (done && !mon_done_prev) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: done=1 with empty scoreboard at cycle %0d", cyc);
            end else begin
               mon_e = sbq.pop_front();
               chk("pass",        {31'd0, pass},        {31'd0, mon_e.pass});
               chk("id_mismatch", {31'd0, id_mismatch}, {31'd0, mon_e.idm});
               chk("ts_mismatch", {31'd0, ts_mismatch}, {31'd0, mon_e.tsm});
               chk("timeout",     {31'd0, timeout},     {31'd0, mon_e.to});
               chk("busy_low",    {31'd0, busy},        32'd0);
               chk("id_q",        id_q,                 mon_e.id);
               chk("ts_q",        ts_q,                 mon_e.ts);
               chk("latency",     cyc - mon_e.start_edge, mon_e.lat);
            end
         end
         mon_done_prev = done;
      end
   end

   initial begin
      int n;
      errors = 0; checks = 0;
      start = 1'b0; reset_n = 1'b0;
      m_id = 32'd0; m_ts = 32'd0;
      configure(EXP_ID, EXP_TS, 1000, 0);
      repeat (3) @(negedge clock);
      chk("reset_outputs", {21'd0, avm_read, avm_address, busy, done, pass,
                            id_mismatch, ts_mismatch, timeout, |id_q, |ts_q}, 32'd0);

      // Auto-start after reset against a slave stuck on word 0.
      sbq.push_back(predict(EXP_ID, EXP_TS, 1000, 0, cyc + 1));
      reset_n = 1'b1;
      wait_done();

      run_check(EXP_ID, EXP_TS, 0, 0, 1'b0);
      run_check(EXP_ID, EXP_TS, 3, 3, 1'b0);
      run_check(EXP_ID, EXP_TS + 32'd1, 0, 0, 1'b0);
      run_check(32'h0000_0001, EXP_TS, 1, 0, 1'b0);
      run_check(EXP_ID, 32'h0000_1234, 2, 1000, 1'b0);
      run_check(EXP_ID, EXP_TS, TO - 1, TO - 1, 1'b0);
      run_check(EXP_ID, EXP_TS, TO, 0, 1'b0);
      run_check(EXP_ID, EXP_TS, 1, 0, 1'b1);
      repeat (5) @(negedge clock);
      chk("single_check", {30'd0, busy, done}, 32'd1);

      for (int i = 0; i < 25; i++) begin
         logic [31:0] rid, rts;
         rid = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
         rts = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
         run_check(rid, rts, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                   bit'($urandom_range(0, 1)));
      end

      // Reset in the middle of the timestamp read, then auto-rerun.
      @(negedge clock);
      configure(EXP_ID, EXP_TS, 1, 1000);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (!(avm_read && avm_address) && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("reach_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("async_read_drop", {31'd0, avm_read}, 32'd0);
      chk("async_outputs", {21'd0, avm_read, avm_address, busy, done, pass,
                            id_mismatch, ts_mismatch, timeout, |id_q, |ts_q}, 32'd0);
      m_id = 32'd0; m_ts = 32'd0;
      @(negedge clock);
      configure(EXP_ID, EXP_TS, 0, 2);
      @(negedge clock);
      sbq.push_back(predict(EXP_ID, EXP_TS, 0, 2, cyc + 1));
      reset_n = 1'b1;
      wait_done();

      repeat (5) @(negedge clock);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
